bist_ctrl: RTL and testbench

BIST_CTRL -- requirements
Module: bist_ctrl

---
 rtl/bist_pkg.sv | 31 +++
 rtl/bist_addr_gen.sv | 34 +++
 rtl/bist_ctrl.sv | 144 ++++++++++++++
 tb/tb_bist_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and March C- helpers for the memory BIST controller.
package bist_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;
   typedef enum logic {OP_READ, OP_WRITE} op_e;

   // E0 is write-only, E5 is read-only; E1..E4 do read then write per address.
   function automatic op_e elem_op(elem_e e, logic ph);
      if (e == E0) return OP_WRITE;
      if (e == E5) return OP_READ;
      return ph ? OP_WRITE : OP_READ;
   endfunction

   function automatic logic elem_last_op(elem_e e, logic ph);
      return (e == E0) || (e == E5) || ph;
   endfunction

   function automatic logic elem_up(elem_e e);
      return !((e == E3) || (e == E4));
   endfunction

   function automatic logic elem_wbit(elem_e e);
      return e[0];
   endfunction

   function automatic logic elem_rbit(elem_e e);
      return ~e[0];
   endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter; load jumps to the start of a sweep, tc_o flags its end.
module bist_addr_gen
   import bist_pkg::*;
#(
   parameter int ADR_SIZE = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic                up_i,
   input  logic                step_i,
   output logic [ADR_SIZE-1:0] addr_o,
   output logic                tc_o
);

   logic [ADR_SIZE-1:0] addr_q;
   logic                up_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         up_q   <= 1'b1;
      end else if (load_i) begin
         addr_q <= up_i ? '0 : '1;
         up_q   <= up_i;
      end else if (step_i) begin
         addr_q <= up_q ? addr_q + 1'b1 : addr_q - 1'b1;
      end
   end

   assign addr_o = addr_q;
   assign tc_o   = up_q ? (addr_q == '1) : (addr_q == '0);

endmodule

// File: rtl/bist_ctrl.sv
// March C- memory BIST controller, one memory op per RUN cycle.
// Define BIST_STOP_ON_FAIL_EN to end the run right after the first mismatch.
module bist_ctrl
   import bist_pkg::*;
#(
   parameter int ADR_SIZE  = 4,
   parameter int DATA_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [ADR_SIZE-1:0]  adress,
   inout  wire  [DATA_SIZE-1:0] data,
   output logic                 wr_en,
   output logic                 read_en,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [ADR_SIZE-1:0]  fail_adr,
   output logic [DATA_SIZE-1:0] fail_data
);

   state_e               state_q;
   elem_e                elem_q, elem_d;
   logic                 phase_q, phase_d;
   logic                 wr_en_q, read_en_q, wbit_q;
   logic                 busy_q, done_q, fail_q;
   logic [ADR_SIZE-1:0]  fail_adr_q;
   logic [DATA_SIZE-1:0] fail_data_q;
   logic                 load, step, up_ld, last, mis, tc;
   op_e                  nxt_op;
   logic [ADR_SIZE-1:0]  addr;

   bist_addr_gen #(.ADR_SIZE(ADR_SIZE)) u_addr (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .up_i   (up_ld),
      .step_i (step),
      .addr_o (addr),
      .tc_o   (tc)
   );

   always_comb begin
      elem_d  = elem_q;
      phase_d = phase_q;
      load    = 1'b0;
      step    = 1'b0;
      up_ld   = 1'b1;
      last    = 1'b0;
      mis     = read_en_q && (data != {DATA_SIZE{elem_rbit(elem_q)}});
      if (state_q == RUN) begin
         if (!elem_last_op(elem_q, phase_q)) begin
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            if (!tc) begin
               step = 1'b1;
            end else if (elem_q == E5) begin
               last = 1'b1;
            end else begin
               // element boundary: reload the counter for the next sweep direction
               elem_d = elem_e'(elem_q + 3'd1);
               load   = 1'b1;
               up_ld  = elem_up(elem_d);
            end
         end
`ifdef BIST_STOP_ON_FAIL_EN
         if (mis) last = 1'b1;
`endif
      end else if (start) begin
         elem_d  = E0;
         phase_d = 1'b0;
         load    = 1'b1;
      end
      nxt_op = elem_op(elem_d, phase_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         elem_q      <= E0;
         phase_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         read_en_q   <= 1'b0;
         wbit_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_adr_q  <= '0;
         fail_data_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q     <= RUN;
                  elem_q      <= elem_d;
                  phase_q     <= phase_d;
                  wr_en_q     <= (nxt_op == OP_WRITE);
                  read_en_q   <= (nxt_op == OP_READ);
                  wbit_q      <= elem_wbit(elem_d);
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  fail_q      <= 1'b0;
                  fail_adr_q  <= '0;
                  fail_data_q <= '0;
               end
            end
            RUN: begin
               if (mis && !fail_q) begin
                  fail_q      <= 1'b1;
                  fail_adr_q  <= addr;
                  fail_data_q <= data;
               end
               if (last) begin
                  state_q   <= DONE;
                  wr_en_q   <= 1'b0;
                  read_en_q <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end else begin
                  elem_q    <= elem_d;
                  phase_q   <= phase_d;
                  wr_en_q   <= (nxt_op == OP_WRITE);
                  read_en_q <= (nxt_op == OP_READ);
                  wbit_q    <= elem_wbit(elem_d);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data      = wr_en_q ? {DATA_SIZE{wbit_q}} : {DATA_SIZE{1'bz}};
   assign adress    = addr;
   assign wr_en     = wr_en_q;
   assign read_en   = read_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fail      = fail_q;
   assign fail_adr  = fail_adr_q;
   assign fail_data = fail_data_q;

endmodule

// File: tb/tb_bist_ctrl.sv
// Scoreboard bench for bist_ctrl on a 16x8 memory model with optional bit0 stuck-at-1 at address 5.
// Honours BIST_STOP_ON_FAIL_EN for the expected length of the faulty run.
module tb_bist_ctrl;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [3:0] adress, fail_adr;
   wire  [7:0] data;
   logic       wr_en, read_en, busy, done, fail;
   logic [7:0] fail_data;

   always #5 clk = ~clk;

   bist_ctrl #(.ADR_SIZE(4), .DATA_SIZE(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .adress    (adress),
      .data      (data),
      .wr_en     (wr_en),
      .read_en   (read_en),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .fail_adr  (fail_adr),
      .fail_data (fail_data)
   );

   // memory model
   logic [7:0] mem [16];
   logic       stuck = 1'b0;
   logic [7:0] rd_val;
   initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   always @(posedge clk) if (wr_en) mem[adress] <= data;
   assign rd_val = mem[adress] | ((stuck && adress == 4'd5) ? 8'h01 : 8'h00);
   assign data   = read_en ? rd_val : 8'bz;

   typedef struct {
      bit         is_rst;
      int         cycles;
      bit         fail;
      logic [3:0] fadr;
      logic [7:0] fdata;
      int         fail_at;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   int perr_prints = 0;

`ifdef BIST_STOP_ON_FAIL_EN
   localparam int FAULT_CYCLES = 27;
`else
   localparam int FAULT_CYCLES = 160;
`endif

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit data_idle_ok();
      return (data === 8'bz) || (data === 8'h00);
   endfunction

   // monitor
   logic rst_at_edge = 1'b0;
   logic done_prev = 1'b0, busy_prev = 1'b0;
   int   cnt = 0, fail_at = -1;
   exp_t e;
   always @(posedge clk) rst_at_edge <= rst;

   always @(negedge clk) begin
      checks++;
      if ((wr_en && read_en) || (!busy && (wr_en || read_en)) ||
          (read_en && data !== rd_val) || (!wr_en && !read_en && !data_idle_ok())) begin
         errors++;
         if (perr_prints < 10) begin
            perr_prints++;
            $display("FAIL protocol: wr_en=%b read_en=%b busy=%b data=%h rd_val=%h (t=%0t)",
                     wr_en, read_en, busy, data, rd_val, $time);
         end
      end
      if (busy && !busy_prev) begin
         cnt = 0;
         fail_at = -1;
      end
      if (fail && fail_at < 0) fail_at = cnt;
      if ((rst_at_edge && !rst) || (done && !done_prev)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: done=%b rst_edge=%b, no expectation queued", done, rst_at_edge);
         end else begin
            e = sb.pop_front();
            if (e.is_rst) begin
               chk("rst_busy", busy, 0);
               chk("rst_wr_en", wr_en, 0);
               chk("rst_read_en", read_en, 0);
               chk("rst_done", done, 0);
               chk("rst_fail", fail, e.fail);
               chk("rst_fail_adr", fail_adr, e.fadr);
               chk("rst_fail_data", fail_data, e.fdata);
               chk("rst_adress", adress, 0);
               chk("rst_data_z", data_idle_ok(), 1);
            end else begin
               chk("run_busy_cycles", cnt, e.cycles);
               chk("run_busy_low", busy, 0);
               chk("run_fail", fail, e.fail);
               chk("run_fail_adr", fail_adr, e.fadr);
               chk("run_fail_data", fail_data, e.fdata);
               chk("run_fail_first_cycle", fail_at, e.fail_at);
            end
         end
      end
      if (busy) cnt++;
      done_prev = done;
      busy_prev = busy;
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, n);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      // reset with start asserted alongside: reset must win
      sb.push_back('{1, 0, 0, 4'h0, 8'h00, -1});
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);

      // fault-free run
      sb.push_back('{0, 160, 0, 4'h0, 8'h00, -1});
      pulse_start();
      wait_done();

      // bit0 stuck-at-1 at address 5, detected by the E1 read in RUN cycle 26
      stuck = 1'b1;
      sb.push_back('{0, FAULT_CYCLES, 1, 4'h5, 8'h01, 27});
      pulse_start();
      wait_done();
      stuck = 1'b0;

      // start re-pulsed in RUN cycle 20 is ignored; fail from previous run is cleared
      sb.push_back('{0, 160, 0, 4'h0, 8'h00, -1});
      pulse_start();
      repeat (20) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();

      // reset sampled at the edge ending RUN cycle 50
      sb.push_back('{1, 0, 0, 4'h0, 8'h00, -1});
      pulse_start();
      repeat (50) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);

      // recovery after the aborted run
      sb.push_back('{0, 160, 0, 4'h0, 8'h00, -1});
      pulse_start();
      wait_done();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
